// File: rtl/jtag_uart_wb_pkg.sv
// Shared definitions for the Wishbone front end of the JTAG UART byte FIFOs:
// register offsets, register bit positions and the bus FSM states.
package jtag_uart_wb_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_FULL_BIT     = 0;
  localparam int ST_EMPTY_BIT    = 1;
  localparam int ST_OVF_BIT      = 2;
  localparam int CTRL_RXIE_BIT   = 0;
  localparam int CTRL_TXIE_BIT   = 1;
  localparam int DATA_RVALID_BIT = 15;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_ACK     = 2'd3
  } state_e;

  // DATA read word for a byte actually popped from the RX FIFO.
  function automatic logic [31:0] rx_word(input logic [7:0] b);
    logic [31:0] w;
    w                  = 32'h0;
    w[DATA_RVALID_BIT] = 1'b1;
    w[7:0]             = b;
    return w;
  endfunction

endpackage

// File: rtl/jtag_uart_wb_if.sv
// Wishbone-classic 32-bit bus bundle between the CPU (master) and the
// JTAG UART bridge (slave).
interface jtag_uart_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/jtag_uart_wb.sv
// Wishbone slave bridging a CPU to the JTAG UART byte FIFOs (DATA/STATUS/CTRL).
// Define JTAG_UART_WB_IRQ_EN to enable the CTRL interrupt enables and irq output.
module jtag_uart_wb
  import jtag_uart_wb_pkg::*;
#(
  parameter bit TX_STALL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  jtag_uart_wb_if.slave     wb,
  output logic [7:0]        uart_data,
  output logic              uart_we,
  output logic              uart_rd,
  input  logic [7:0]        uart_q,
  input  logic              uart_full,
  input  logic              uart_empty,
  output logic              irq
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_dat;
  logic        r_we;
  logic [7:0]  r_data;
  logic        r_ovf;

  logic        w_acc;
  logic [1:0]  w_sel;
  logic        w_rd;
  logic        w_push;
  logic        w_data_ld;
  logic        w_dat_ld;
  logic [31:0] w_dat_nxt;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_ctrl_we;
  logic [31:0] w_ctrl_word;

  assign w_acc = (r_state == S_IDLE) & wb.wb_cyc_i & wb.wb_stb_i;
  assign w_sel = wb.wb_adr_i[3:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_sel == REG_DATA && !wb.wb_we_i && !uart_empty)
            w_next = S_RD_WAIT;
          else if (w_sel == REG_DATA && wb.wb_we_i && uart_full && TX_STALL)
            w_next = S_WR_WAIT;
          else
            w_next = S_ACK;
        end
      end
      S_RD_WAIT: w_next = S_ACK;
      S_WR_WAIT: if (!uart_full) w_next = S_ACK;
      S_ACK:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Every accepted transfer reloads the read word (0 unless a register is read);
  // a non-empty DATA read defers the load to RD_WAIT, when uart_q is valid.
  always_comb begin
    w_rd      = 1'b0;
    w_push    = 1'b0;
    w_data_ld = 1'b0;
    w_dat_ld  = 1'b0;
    w_dat_nxt = 32'h0;
    w_ovf_set = 1'b0;
    w_ovf_clr = 1'b0;
    w_ctrl_we = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_dat_ld = 1'b1;
          case (w_sel)
            REG_DATA: begin
              if (wb.wb_we_i) begin
                w_data_ld = 1'b1;
                if (!uart_full)     w_push    = 1'b1;
                else if (!TX_STALL) w_ovf_set = 1'b1;
              end else if (!uart_empty) begin
                w_rd     = 1'b1;
                w_dat_ld = 1'b0;
              end
            end
            REG_STATUS: begin
              if (!wb.wb_we_i) begin
                w_dat_nxt[ST_FULL_BIT]  = uart_full;
                w_dat_nxt[ST_EMPTY_BIT] = uart_empty;
                w_dat_nxt[ST_OVF_BIT]   = r_ovf;
                w_ovf_clr               = 1'b1;
              end
            end
            REG_CTRL: begin
              if (wb.wb_we_i) w_ctrl_we = 1'b1;
              else            w_dat_nxt = w_ctrl_word;
            end
            REG_RSVD: w_dat_nxt = 32'h0;
            default:  w_dat_nxt = 32'h0;
          endcase
        end
      end
      S_RD_WAIT: begin
        w_dat_ld  = 1'b1;
        w_dat_nxt = rx_word(uart_q);
      end
      S_WR_WAIT: if (!uart_full) w_push = 1'b1;
      default: ;
    endcase
  end

  // Overflow set wins over the STATUS read clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat  <= 32'h0;
      r_we   <= 1'b0;
      r_data <= 8'h0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_dat_ld)  r_dat  <= w_dat_nxt;
      if (w_data_ld) r_data <= wb.wb_dat_i[7:0];
      r_we  <= w_push;
      r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
    end
  end

`ifdef JTAG_UART_WB_IRQ_EN
  logic [1:0] r_ctrl;
  logic       r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= 2'b00;
      r_irq  <= 1'b0;
    end else begin
      if (w_ctrl_we) r_ctrl <= wb.wb_dat_i[1:0];
      r_irq <= (r_ctrl[CTRL_RXIE_BIT] & ~uart_empty) |
               (r_ctrl[CTRL_TXIE_BIT] & ~uart_full);
    end
  end

  assign w_ctrl_word = {30'h0, r_ctrl};
  assign irq         = r_irq;
`else
  assign w_ctrl_word = 32'h0;
  assign irq         = 1'b0;
`endif

  logic w_unused;
  assign w_unused = &{1'b0, wb.wb_adr_i[1:0], wb.wb_dat_i[31:8], w_ctrl_we};

  assign wb.wb_ack_o = (r_state == S_ACK);
  assign wb.wb_dat_o = r_dat;
  assign uart_we     = r_we;
  assign uart_data   = r_data;
  // The pop strobe is combinational on the accept cycle; keep it quiet in reset.
  assign uart_rd     = w_rd & rst_n;

endmodule

// File: tb/tb_jtag_uart_wb.sv
// Scoreboard bench for jtag_uart_wb: a stalling and a dropping instance, each
// with a one-cycle-latency RX FIFO model.
module tb_jtag_uart_wb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int fails  = 0;

`ifdef JTAG_UART_WB_IRQ_EN
  localparam logic        IRQ_EXP  = 1'b1;
  localparam logic [31:0] CTRL_EXP = 32'h1;
`else
  localparam logic        IRQ_EXP  = 1'b0;
  localparam logic [31:0] CTRL_EXP = 32'h0;
`endif

  jtag_uart_wb_if ifa ();
  jtag_uart_wb_if ifb ();

  logic [7:0] data_a, q_a, rx_a, data_b, q_b, rx_b;
  logic       we_a, rd_a, full_a, empty_a, irq_a;
  logic       we_b, rd_b, full_b, empty_b, irq_b;

  jtag_uart_wb #(.TX_STALL(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wb(ifa),
    .uart_data(data_a), .uart_we(we_a), .uart_rd(rd_a), .uart_q(q_a),
    .uart_full(full_a), .uart_empty(empty_a), .irq(irq_a)
  );

  jtag_uart_wb #(.TX_STALL(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wb(ifb),
    .uart_data(data_b), .uart_we(we_b), .uart_rd(rd_b), .uart_q(q_b),
    .uart_full(full_b), .uart_empty(empty_b), .irq(irq_b)
  );

  // Non-showahead RX FIFO: the popped byte is only present the cycle after rd.
  always @(posedge clk) begin
    q_a <= rd_a ? rx_a : 8'h00;
    q_b <= rd_b ? rx_b : 8'h00;
  end

  typedef struct { logic [31:0] dat; bit chk; int cyc; } exp_t;
  typedef struct { logic [7:0] dat; int cyc; } txe_t;
  exp_t qa[$], qb[$];
  txe_t ta[$], tq[$];
  exp_t ea, eb;
  txe_t xa, xb;
  int   rd_cnt_a = 0, rd_cnt_b = 0, both_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.wb_ack_o) begin
      if (qa.size() == 0) begin
        checks++; fails++;
        $display("FAIL ack_a_unexpected actual=ack at cycle %0d required=no ack", cyc_cnt);
      end else begin
        ea = qa.pop_front();
        check("ack_a_cycle", cyc_cnt, ea.cyc);
        if (ea.chk) check("dat_a", ifa.wb_dat_o, ea.dat);
      end
    end
    if (ifb.wb_ack_o) begin
      if (qb.size() == 0) begin
        checks++; fails++;
        $display("FAIL ack_b_unexpected actual=ack at cycle %0d required=no ack", cyc_cnt);
      end else begin
        eb = qb.pop_front();
        check("ack_b_cycle", cyc_cnt, eb.cyc);
        if (eb.chk) check("dat_b", ifb.wb_dat_o, eb.dat);
      end
    end
    if (we_a) begin
      if (ta.size() == 0) begin
        checks++; fails++;
        $display("FAIL we_a_unexpected actual=push 0x%02h required=no push", data_a);
      end else begin
        xa = ta.pop_front();
        check("tx_a_data", data_a, xa.dat);
        check("tx_a_cycle", cyc_cnt, xa.cyc);
      end
    end
    if (we_b) begin
      if (tq.size() == 0) begin
        checks++; fails++;
        $display("FAIL we_b_unexpected actual=push 0x%02h required=no push", data_b);
      end else begin
        xb = tq.pop_front();
        check("tx_b_data", data_b, xb.dat);
        check("tx_b_cycle", cyc_cnt, xb.cyc);
      end
    end
    if (rd_a) rd_cnt_a++;
    if (rd_b) rd_cnt_b++;
    if ((we_a && rd_a) || (we_b && rd_b)) both_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input bit act, input bit we,
                       input logic [3:0] adr, input logic [31:0] dat);
    if (sel) begin
      ifb.wb_cyc_i = act; ifb.wb_stb_i = act; ifb.wb_we_i = we;
      ifb.wb_adr_i = adr; ifb.wb_dat_i = dat;
    end else begin
      ifa.wb_cyc_i = act; ifa.wb_stb_i = act; ifa.wb_we_i = we;
      ifa.wb_adr_i = adr; ifa.wb_dat_i = dat;
    end
  endtask

  task automatic exp_tx(input bit sel, input logic [7:0] dat, input int lat);
    txe_t t;
    t.dat = dat;
    t.cyc = cyc_cnt + lat;
    if (sel) tq.push_back(t);
    else     ta.push_back(t);
  endtask

  // Called just after a rising edge; the strobe is held through the ACK cycle.
  task automatic xfer(input bit sel, input bit we, input logic [3:0] adr,
                      input logic [31:0] dat, input logic [31:0] exp_dat,
                      input bit chk, input int lat);
    exp_t e;
    bit   got;
    e.dat = exp_dat;
    e.chk = chk;
    e.cyc = cyc_cnt + lat;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
    drive(sel, 1'b1, we, adr, dat);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = sel ? ifb.wb_ack_o : ifa.wb_ack_o;
    end
    if (!got) begin
      checks++; fails++;
      $display("FAIL ack_timeout actual=no ack in 20 cycles required=ack (dut %0d adr 0x%0h)", sel, adr);
    end
    tick();
    drive(sel, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0);
    full_a = 1'b0; empty_a = 1'b1; rx_a = 8'h00;
    full_b = 1'b0; empty_b = 1'b1; rx_b = 8'h00;
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_ack",   ifa.wb_ack_o, 0);
    check("rst_dat",   ifa.wb_dat_o, 0);
    check("rst_we",    we_a, 0);
    check("rst_rd",    rd_a, 0);
    check("rst_data",  data_a, 0);
    check("rst_irq",   irq_a, 0);
    tick();
    rst_n = 1'b1;
    tick();

    rx_a = 8'h41; empty_a = 1'b0; r0 = rd_cnt_a;
    xfer(0, 0, 4'h0, 32'h0, 32'h0000_8041, 1, 2);
    check("rd_pulses_full_rx", rd_cnt_a - r0, 1);

    empty_a = 1'b1; r0 = rd_cnt_a;
    xfer(0, 0, 4'h0, 32'h0, 32'h0, 1, 1);
    check("rd_pulses_empty_rx", rd_cnt_a - r0, 0);

    exp_tx(0, 8'hA5, 1);
    xfer(0, 1, 4'h0, 32'hFFFF_FFA5, 32'h0, 0, 1);
    xfer(0, 0, 4'hC, 32'h0, 32'h0, 1, 1);
    xfer(0, 1, 4'hC, 32'hFFFF_FFFF, 32'h0, 0, 1);
    xfer(0, 0, 4'h4, 32'h0, 32'h2, 1, 1);

    full_a = 1'b1;
    exp_tx(0, 8'h5A, 6);
    fork
      begin
        repeat (5) tick();
        full_a = 1'b0;
      end
      xfer(0, 1, 4'h0, 32'h0000_005A, 32'h0, 0, 6);
    join

    xfer(0, 1, 4'h4, 32'h7, 32'h0, 0, 1);
    xfer(0, 0, 4'h4, 32'h0, 32'h2, 1, 1);

    xfer(0, 1, 4'h8, 32'h1, 32'h0, 0, 1);
    empty_a = 1'b0;
    #1 check("irq_not_comb", irq_a, 0);
    @(negedge clk) check("irq_before_edge", irq_a, 0);
    @(negedge clk) check("irq_rx_ready", irq_a, IRQ_EXP);
    tick();
    xfer(0, 0, 4'h8, 32'h0, CTRL_EXP, 1, 1);
    empty_a = 1'b1;
    xfer(0, 1, 4'h8, 32'h0, 32'h0, 0, 1);
    tick();
    tick();
    check("irq_disabled", irq_a, 0);

    empty_b = 1'b0; full_b = 1'b1;
    xfer(1, 1, 4'h0, 32'h33, 32'h0, 0, 1);
    xfer(1, 0, 4'h4, 32'h0, 32'h5, 1, 1);
    xfer(1, 0, 4'h4, 32'h0, 32'h1, 1, 1);
    full_b = 1'b0; empty_b = 1'b1;

    rx_a = 8'h41; empty_a = 1'b0;
    xfer(0, 0, 4'h0, 32'h0, 32'h0000_8041, 1, 2);
    rx_a = 8'h77;
    drive(0, 1'b1, 1'b0, 4'h0, 32'h0);
    @(negedge clk) check("rd_before_reset", rd_a, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rdw_rst_ack",  ifa.wb_ack_o, 0);
    check("rdw_rst_dat",  ifa.wb_dat_o, 0);
    check("rdw_rst_we",   we_a, 0);
    check("rdw_rst_rd",   rd_a, 0);
    check("rdw_rst_data", data_a, 0);
    check("rdw_rst_irq",  irq_a, 0);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    rx_a = 8'h41; r0 = rd_cnt_a;
    xfer(0, 0, 4'h0, 32'h0, 32'h0000_8041, 1, 2);
    check("rd_pulses_after_reset", rd_cnt_a - r0, 1);
    empty_a = 1'b1;
    xfer(0, 0, 4'h0, 32'h0, 32'h0, 1, 1);
    repeat (2) tick();

    check("pending_ack_a", qa.size(), 0);
    check("pending_ack_b", qb.size(), 0);
    check("pending_tx_a",  ta.size(), 0);
    check("pending_tx_b",  tq.size(), 0);
    check("we_rd_exclusive", both_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
